// File: rtl/universal_register.sv
// Purpose: SIZE_-bit register with load/clear/shift/rotate/inc/dec ops plus carry, zero and change status.
// Latency: one clock from an enabled edge to the new q_/carry_/changed_; zero_ is combinational from q_.
// Backpressure: none; load_reg_ is a plain update enable and the register holds whenever it is low.
module universal_register #(
  parameter int               SIZE_      = 8,
  parameter logic [SIZE_-1:0] RESET_VAL_ = '0,
  parameter bit               SATURATE_  = 1'b0
) (
  input  logic             clk_,
  input  logic             rst_n_,
  input  logic             load_reg_,
  input  logic [2:0]       mode_,
  input  logic [SIZE_-1:0] d_,
  input  logic             ser_in_,
  output logic [SIZE_-1:0] q_,
  output logic             carry_,
  output logic             zero_,
  output logic             changed_
);

  localparam logic [2:0] MODE_LOAD  = 3'b000;
  localparam logic [2:0] MODE_CLEAR = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_INC   = 3'b110;

  localparam logic [SIZE_-1:0] ONE = SIZE_'(1);

  logic [SIZE_-1:0] q_nxt;
  logic             carry_nxt;
  logic             all_ones;
  logic             all_zero;

  assign all_ones = &q_;
  assign all_zero = ~|q_;

  // Next value and carry/borrow for the selected operation; every code is decoded.
  always_comb begin
    q_nxt     = q_;
    carry_nxt = 1'b0;
    case (mode_)
      MODE_LOAD:  q_nxt = d_;
      MODE_CLEAR: q_nxt = '0;
      MODE_SHL: begin
        q_nxt     = {q_[SIZE_-2:0], ser_in_};
        carry_nxt = q_[SIZE_-1];
      end
      MODE_SHR: begin
        q_nxt     = {ser_in_, q_[SIZE_-1:1]};
        carry_nxt = q_[0];
      end
      MODE_ROL: begin
        q_nxt     = {q_[SIZE_-2:0], q_[SIZE_-1]};
        carry_nxt = q_[SIZE_-1];
      end
      MODE_ROR: begin
        q_nxt     = {q_[0], q_[SIZE_-1:1]};
        carry_nxt = q_[0];
      end
      MODE_INC: begin
        // Carry flags the wrap; in saturating builds the value sticks at all-ones instead.
        carry_nxt = all_ones;
        q_nxt     = (SATURATE_ && all_ones) ? q_ : q_ + ONE;
      end
      default: begin
        // DEC: carry is the borrow out of zero; saturating builds hold at zero.
        carry_nxt = all_zero;
        q_nxt     = (SATURATE_ && all_zero) ? q_ : q_ - ONE;
      end
    endcase
  end

  // State update: async reset, enabled ops load q_/carry_, changed_ pulses only on a real change.
  always_ff @(posedge clk_ or negedge rst_n_) begin
    if (!rst_n_) begin
      q_       <= RESET_VAL_;
      carry_   <= 1'b0;
      changed_ <= 1'b0;
    end else if (load_reg_) begin
      q_       <= q_nxt;
      carry_   <= carry_nxt;
      changed_ <= (q_nxt != q_);
    end else begin
      changed_ <= 1'b0;
    end
  end

  // Zero flag tracks q_ with no added latency.
  always_comb begin
    zero_ = all_zero;
  end

endmodule

// File: doc/universal_register.md
Name: universal_register

Overview:
Parametrised successor to the basic load register in the factorial datapath. Holds a SIZE_-bit value and supports eight operations, selected by mode_: load, clear, shift left, shift right, rotate left, rotate right, increment and decrement. Each update also produces carry/borrow, zero and change-detect status for the controller FSM. It replaces ad-hoc counter and operand registers; the factorial down-counter uses DEC mode.

Parameters:
SIZE_, 8, data width in bits (>=2)
RESET_VAL_, 0, value of q_ after reset (SIZE_ bits)
SATURATE_, 0, 0 = INC/DEC wrap around; 1 = INC/DEC saturate at the limits

Ports:
clk_  input  1  clock, rising-edge
rst_n_  input  1  asynchronous active-low reset
load_reg_  input  1  update enable; when 0 the register holds whatever mode_ is
mode_  input  3  operation select (encoding below)
d_  input  SIZE_  parallel load data
ser_in_  input  1  serial bit shifted in by SHL/SHR
q_  output  SIZE_  register contents
carry_  output  1  registered status bit from the last enabled operation
zero_  output  1  combinational, 1 when q_ == 0
changed_  output  1  registered; 1 for one cycle after an enabled update that altered q_

Behaviour:
- Reset (rst_n_ = 0): asynchronous, takes effect immediately including mid-operation. q_ = RESET_VAL_, carry_ = 0, changed_ = 0. zero_ follows q_.
- First update after reset release: first rising edge with rst_n_ = 1 and load_reg_ = 1.
- load_reg_ = 0 at a clock edge: q_ and carry_ hold; changed_ <= 0.
- load_reg_ = 1 at a clock edge: single-cycle latency; the new q_ is visible after that edge. Operations by mode_:
  - 000 LOAD: q <= d_; carry <= 0
  - 001 CLEAR: q <= 0; carry <= 0
  - 010 SHL: q <= {q[SIZE_-2:0], ser_in_}; carry <= q[SIZE_-1]
  - 011 SHR: q <= {ser_in_, q[SIZE_-1:1]}; carry <= q[0]
  - 100 ROL: q <= {q[SIZE_-2:0], q[SIZE_-1]}; carry <= q[SIZE_-1]
  - 101 ROR: q <= {q[0], q[SIZE_-1:1]}; carry <= q[0]
  - 110 INC: q <= q+1 (modulo 2^SIZE_); carry <= (q == all-ones). With SATURATE_ = 1 and q == all-ones: q holds and carry <= 1.
  - 111 DEC: q <= q-1 (modulo 2^SIZE_); carry <= (q == 0), which is the borrow. With SATURATE_ = 1 and q == 0: q holds and carry <= 1.
- changed_ <= (next q != current q) on every enabled edge. A LOAD of the identical value, a saturated hold, or ROL/ROR of all-zeros or all-ones gives changed_ = 0.
- zero_ is purely combinational from q_ and has no latency relative to q_.
- All arithmetic is SIZE_ bits wide, unsigned, with no sign extension.
- mode_ is fully decoded; there are no illegal codes.
- d_ and ser_in_ are ignored in modes that do not use them.
- Simultaneous events:
  - Reset assertion coincident with a clock edge: reset wins.
  - Reset deasserting on the same edge as load_reg_ = 1: the update is not required to occur. Benches must deassert reset away from clock edges.

Test Plan:
(Defaults SIZE_=8, RESET_VAL_=0, SATURATE_=0 unless stated.)
- Reset then load_reg_=0, d_=8'h01 for 2 cycles -> q_=8'h00, zero_=1, carry_=0, changed_=0. Then load_reg_=1, mode_=000 -> next cycle q_=8'h01, changed_=1, zero_=0.
- Load 8'hFF, then INC -> q_=8'h00, carry_=1, zero_=1. Repeat with SATURATE_=1 -> q_ stays 8'hFF, carry_=1, changed_=0.
- Load 8'h05, then DEC x5 -> q_ 04,03,02,01,00 with carry_=0. A sixth DEC -> q_=8'hFF, carry_=1 (with SATURATE_=1: q_ stays 00, carry_=1).
- Load 8'h81, then SHL with ser_in_=0 -> q_=8'h02, carry_=1. Then ROR -> q_=8'h01, carry_=0. Then ROR -> q_=8'h80, carry_=1.
- Load 8'hA5, hold load_reg_=0 with mode_ cycling through all codes for 8 cycles -> q_ stays 8'hA5, carry_ unchanged, changed_=0.
- Pull rst_n_ low between clock edges while incrementing from 8'h10 -> q_ goes to 00 immediately, before the next edge. With RESET_VAL_=8'h3C -> q_=8'h3C.
